sram_like_arbiter: RTL and testbench

//  Shares one sram-like memory port between the instruction-fetch and data (EXE/MEM) requesters.

---
 rtl/sram_like_arbiter_pkg.sv | 22 ++
 rtl/sram_like_req_mux.sv | 37 +++
 rtl/sram_like_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter: FSM states, owner select and transfer sizes.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Consecutive DATA grants tolerated while fetch waits (starve guard builds only).
  localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/sram_like_req_mux.sv
// Combinational owner-select of the request fields driven onto the shared memory port.
module sram_like_req_mux
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  owner_e            owner,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    if (owner == OWNER_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between fetch and data requesters, one transaction in flight,
// data side prioritised. Optional fetch starvation guard: define INST_STARVE_GUARD_EN.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_p0, state_nxt;
  owner_e     owner_p0, owner_nxt;
  logic       guard_hit;
  logic       pick_data;

  // Data wins unless the starve guard forces a waiting fetch through.
  assign pick_data = data_req && !guard_hit;

`ifdef INST_STARVE_GUARD_EN
  logic [1:0] starve_p0;
  logic       arb_cycle;

  assign arb_cycle = (state_p0 == ARB_IDLE);
  assign guard_hit = (starve_p0 == STARVE_LIMIT) && inst_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_p0 <= 2'd0;
    end else if (arb_cycle && !pick_data && inst_req) begin
      starve_p0 <= 2'd0;
    end else if (arb_cycle && pick_data && inst_req && (starve_p0 != STARVE_LIMIT)) begin
      starve_p0 <= starve_p0 + 2'd1;
    end
  end
`else
  assign guard_hit = 1'b0;
`endif

  // Stage p0: state and owner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ARB_IDLE;
      owner_p0 <= OWNER_INST;
    end else begin
      state_p0 <= state_nxt;
      owner_p0 <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    owner_nxt = owner_p0;
    unique case (state_p0)
      ARB_IDLE: begin
        if (pick_data) begin
          owner_nxt = OWNER_DATA;
          state_nxt = ARB_REQ;
        end else if (inst_req) begin
          owner_nxt = OWNER_INST;
          state_nxt = ARB_REQ;
        end
      end
      ARB_REQ:  if (mem_addr_ok) state_nxt = ARB_RESP;
      ARB_RESP: if (mem_data_ok) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  logic in_req;
  logic in_resp;
  logic own_data;

  assign in_req   = (state_p0 == ARB_REQ);
  assign in_resp  = (state_p0 == ARB_RESP);
  assign own_data = (owner_p0 == OWNER_DATA);

  assign mem_req      = in_req;
  assign inst_addr_ok = in_req  && !own_data && mem_addr_ok;
  assign data_addr_ok = in_req  &&  own_data && mem_addr_ok;
  assign inst_data_ok = in_resp && !own_data && mem_data_ok;
  assign data_data_ok = in_resp &&  own_data && mem_data_ok;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  sram_like_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_mux (
    .owner      (owner_p0),
    .inst_wr    (inst_wr),
    .inst_size  (inst_size),
    .inst_addr  (inst_addr),
    .inst_wdata (inst_wdata),
    .data_wr    (data_wr),
    .data_size  (data_size),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed-plus-random bench for sram_like_arbiter against a transaction-level arbitration model.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

`ifdef INST_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, iwr, dreq, dwr;
  logic [1:0]  isize, dsize;
  logic [31:0] iaddr, iwdata, daddr, dwdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int starve = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(ireq), .inst_wr(iwr), .inst_size(isize), .inst_addr(iaddr), .inst_wdata(iwdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(dreq), .data_wr(dwr), .data_size(dsize), .data_addr(daddr), .data_wdata(dwdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: data first, except a fetch starved for STARVE_LIMIT data grants.
  function automatic bit model_winner();
    if (GUARD && starve == 3 && ireq) return 1'b0;
    return dreq ? 1'b1 : 1'b0;
  endfunction

  task automatic model_grant(input bit w);
    if (!w) starve = 0;
    else if (ireq && starve < 3) starve++;
  endtask

  task automatic new_inst();
    iwr = 1'($urandom_range(0, 1)); isize = 2'($urandom_range(0, 2));
    iaddr = $urandom; iwdata = $urandom;
  endtask

  task automatic new_data();
    dwr = 1'($urandom_range(0, 1)); dsize = 2'($urandom_range(0, 2));
    daddr = $urandom; dwdata = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      mem_addr_ok = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_data_ok = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("idle_quiet", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      @(negedge clk);
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  // One full transaction starting in an IDLE cycle with the current request inputs.
  task automatic run_txn(input int ad, input int dd, input logic [31:0] rd,
                         input bit rearm, input bit raise);
    bit w;
    bit last;
    mem_addr_ok = 1'($urandom_range(0, 1));
    mem_data_ok = 1'($urandom_range(0, 1));
    #1;
    chk("arb_quiet", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    w = model_winner();
    model_grant(w);
    @(negedge clk);
    for (int k = 0; k <= ad; k++) begin
      last = (k == ad);
      mem_addr_ok = last;
      mem_data_ok = !last && 1'($urandom_range(0, 1));
      if (k == 0 && raise) begin
        if (w && !ireq) begin ireq = 1'b1; new_inst(); end
        if (!w && !dreq) begin dreq = 1'b1; new_data(); end
      end
      #1;
      if (w) chk("req_fields", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata},
                 {1'b1, dwr, dsize, daddr, dwdata});
      else   chk("req_fields", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata},
                 {1'b1, iwr, isize, iaddr, iwdata});
      chk("req_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
          {!w && last, w && last, 2'b00});
      @(negedge clk);
    end
    mem_addr_ok = 1'b0;
    if (w) begin dreq = rearm; if (rearm) new_data(); end
    else   begin ireq = rearm; if (rearm) new_inst(); end
    for (int k = 0; k <= dd; k++) begin
      last = (k == dd);
      mem_data_ok = last;
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_rdata = last ? rd : $urandom;
      #1;
      chk("resp_quiet", {mem_req, inst_addr_ok, data_addr_ok}, 0);
      chk("resp_oks", {inst_data_ok, data_data_ok}, {!w && last, w && last});
      chk("rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
      @(negedge clk);
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 4 && (ireq || dreq); g++)
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ireq = 0; iwr = 0; isize = 0; iaddr = 0; iwdata = 0;
    dreq = 0; dwr = 0; dsize = 0; daddr = 0; dwdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    @(negedge clk);
    reset = 1'b0;
    starve = 0;

    // Single fetch read from the boot vector.
    ireq = 1'b1; iwr = 1'b0; isize = SIZE_WORD; iaddr = 32'hBFC00000; iwdata = 32'h0;
    run_txn(1, 1, 32'h3C1DA000, 1'b0, 1'b0);

    // Simultaneous requests: the store goes first, fetch follows.
    ireq = 1'b1; iwr = 1'b0; isize = SIZE_WORD; iaddr = 32'hBFC00004; iwdata = 32'h0;
    dreq = 1'b1; dwr = 1'b1; dsize = SIZE_WORD; daddr = 32'h80000010; dwdata = 32'h1234;
    run_txn(0, 0, $urandom, 1'b0, 1'b0);
    run_txn(0, 1, $urandom, 1'b0, 1'b0);

    // Long address stall while the other side raises its request.
    ireq = 1'b1; new_inst();
    run_txn(5, 0, $urandom, 1'b0, 1'b1);
    drain();

    // Spurious handshakes in IDLE.
    idle_cycles(3);

    // Reset during RESP drops the response.
    ireq = 1'b1; new_inst();
    #1;
    chk("rst_arb", {mem_req, inst_addr_ok}, 0);
    @(negedge clk);
    mem_addr_ok = 1'b1;
    #1;
    chk("rst_addr_ok", {mem_req, inst_addr_ok, data_addr_ok}, 3'b110);
    @(negedge clk);
    ireq = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; starve = 0; mem_data_ok = 1'b1;
    #1;
    chk("rst_drop", {mem_req, inst_data_ok, data_data_ok}, 0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    chk("rst_idle", mem_req, 0);
    @(negedge clk);

    // Continuous data traffic with a waiting fetch.
    ireq = 1'b1; new_inst(); dreq = 1'b1; new_data();
    for (int g = 0; g < 4; g++) run_txn(0, $urandom_range(0, 1), $urandom, 1'b1, 1'b0);
    dreq = 1'b0;
    drain();

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      if (!ireq && $urandom_range(0, 1) == 1) begin ireq = 1'b1; new_inst(); end
      if (!dreq && $urandom_range(0, 1) == 1) begin dreq = 1'b1; new_data(); end
      if (!ireq && !dreq) begin
        idle_cycles(1);
        ireq = 1'b1; new_inst();
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
